// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/stall controller and the forwarding unit:
// FSM states, the load writeback select code and the bubble NOP encoding.
package hazard_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam logic [1:0]  SEL_DATA_LOAD = 2'd3;
  localparam logic [31:0] NOP_INSN      = 32'h0000_0013;  // addi x0, x0, 0

  function automatic logic early_match(input logic [4:0] rs,
                                       input logic       uses_early,
                                       input logic [4:0] rd);
    return uses_early && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_md_watchdog.sv
// Mul/div watchdog: clearable up-counter that saturates at MD_TIMEOUT-1 and
// flags the terminal count.
module md_watchdog #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  localparam int W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [W-1:0] TC = W'(MD_TIMEOUT - 1);

  logic [W-1:0] count;

  assign terminal = (count == TC);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && !terminal) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock: load-to-ID-operand stalls, mul/div occupancy of EXE and
// redirect flushes. Performance counters exist only with HAZARD_PERF_CNT_EN.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rsA,
  input  logic [4:0]       id_rsB,
  input  logic             id_uses_rsA_early,
  input  logic             id_uses_rsB_early,
  input  logic             id_redirect,
  input  logic             exe_valid,
  input  logic [4:0]       exe_rd,
  input  logic             exe_wr_en,
  input  logic [1:0]       exe_sel_data,
  input  logic             exe_is_muldiv,
  input  logic             muldiv_done,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idexe_stall,
  output logic             idexe_bubble,
  output logic             exemem_bubble,
  output logic             ifid_flush,
  output logic             muldiv_start,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output state_t           fsm_state
);

  // Mul/div handshake: muldiv_start is a one-cycle request issued on entry to
  // MD_WAIT; muldiv_done is a one-cycle completion pulse, honoured only in
  // MD_WAIT, or already high in IDLE meaning the result needs no wait.
  state_t state, state_next;
  logic   wd_clear, wd_inc, wd_tc, timeout_set;
  logic   load_hazard, any_stall;

  assign fsm_state = state;

  assign load_hazard = id_valid && exe_valid && exe_wr_en &&
                       (exe_sel_data == SEL_DATA_LOAD) && (exe_rd != 5'd0) &&
                       (early_match(id_rsA, id_uses_rsA_early, exe_rd) ||
                        early_match(id_rsB, id_uses_rsB_early, exe_rd));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_timeout <= 1'b0;
    end else if (timeout_set) begin
      md_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    pc_stall      = 1'b0;
    ifid_stall    = 1'b0;
    idexe_stall   = 1'b0;
    idexe_bubble  = 1'b0;
    exemem_bubble = 1'b0;
    muldiv_start  = 1'b0;
    wd_clear      = 1'b0;
    wd_inc        = 1'b0;
    timeout_set   = 1'b0;
    case (state)
      IDLE: begin
        if (exe_valid && exe_is_muldiv && !muldiv_done) begin
          muldiv_start  = 1'b1;
          pc_stall      = 1'b1;
          ifid_stall    = 1'b1;
          idexe_stall   = 1'b1;
          exemem_bubble = 1'b1;
          wd_clear      = 1'b1;
          state_next    = MD_WAIT;
        end else if (load_hazard) begin
          // One bubble suffices: next cycle the load sits in MEM and forwards.
          pc_stall     = 1'b1;
          ifid_stall   = 1'b1;
          idexe_bubble = 1'b1;
        end
      end
      MD_WAIT: begin
        wd_inc = 1'b1;
        if (muldiv_done) begin
          state_next = IDLE;
        end else if (wd_tc) begin
          timeout_set = 1'b1;
          state_next  = IDLE;
        end else begin
          pc_stall      = 1'b1;
          ifid_stall    = 1'b1;
          idexe_stall   = 1'b1;
          exemem_bubble = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A held ID instruction re-issues its redirect once the stall lifts.
  assign any_stall  = pc_stall || ifid_stall || idexe_stall ||
                      idexe_bubble || exemem_bubble;
  assign ifid_flush = id_redirect && id_valid && !any_stall;

  md_watchdog #(
    .MD_TIMEOUT(MD_TIMEOUT)
  ) u_md_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .inc     (wd_inc),
    .terminal(wd_tc)
  );

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (pc_stall) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (ifid_flush) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
